pc_fetch_ctrl: RTL and testbench

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl.sv | 89 ++++++++
 tb/tb_pc_fetch_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch PC register and request FSM (BOOT/FETCH/HOLD) with trap/redirect/stall priority.
// Optional macro PC_MISALIGN_TRAP_EN turns misaligned redirect targets into traps and pulses misalign_o.
`default_nettype none

module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_plus4_i,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  input  logic        trap_i,
  input  logic        imem_ready_i,
  output logic [31:0] pc_o,
  output logic        imem_req_o,
  output logic        pc_valid_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state;
  logic   target_bad;

`ifdef PC_MISALIGN_TRAP_EN
  assign target_bad = |redirect_target_i[1:0];
`else
  assign target_bad = 1'b0;
`endif

  assign pc_valid_o = (state == FETCH) & imem_ready_i & ~stall_i & ~redirect_valid_i & ~trap_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc_o       <= RESET_VECTOR;
      imem_req_o <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      case (state)
        BOOT: begin
          state      <= FETCH;
          imem_req_o <= 1'b1;
        end
        FETCH, HOLD: begin
          if (trap_i) begin
            pc_o       <= TRAP_VECTOR;
            state      <= FETCH;
            imem_req_o <= 1'b1;
          end else if (redirect_valid_i) begin
            if (target_bad) begin
              pc_o       <= TRAP_VECTOR;
              misalign_o <= 1'b1;
            end else begin
              pc_o <= redirect_target_i & 32'hFFFF_FFFC;
            end
            state      <= FETCH;
            imem_req_o <= 1'b1;
          end else if (stall_i) begin
            state      <= HOLD;
            imem_req_o <= 1'b0;
          end else begin
            // Leaving HOLD reissues the same PC; only an accepted fetch advances it.
            if (state == FETCH && imem_ready_i) begin
              pc_o <= pc_plus4_i & 32'hFFFF_FFFC;
            end
            state      <= FETCH;
            imem_req_o <= 1'b1;
          end
        end
        default: begin
          state      <= BOOT;
          imem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed scoreboard bench for pc_fetch_ctrl.
`default_nettype none

module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap;
  logic        imem_ready;
  logic [31:0] pc;
  logic        imem_req;
  logic        pc_valid;
  logic        misalign;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        req;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  pc_fetch_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc_plus4_i        (pc_plus4),
    .stall_i           (stall),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .trap_i            (trap),
    .imem_ready_i      (imem_ready),
    .pc_o              (pc),
    .imem_req_o        (imem_req),
    .pc_valid_o        (pc_valid),
    .misalign_o        (misalign)
  );

  // External PC adder.
  assign pc_plus4 = pc + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fails++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk_word({e.tag, ".pc"}, pc, e.pc);
      chk_bit({e.tag, ".req"}, imem_req, e.req);
      chk_bit({e.tag, ".mis"}, misalign, e.mis);
    end
  endtask

  // Drive one cycle of inputs, check pc_valid before the edge, queue post-edge expectation.
  task automatic cyc(input string tag, input logic st, input logic rv, input logic [31:0] tgt,
                     input logic tr, input logic rdy, input logic exp_valid,
                     input logic [31:0] exp_pc, input logic exp_req, input logic exp_mis);
    exp_t e;
    stall = st; redirect_valid = rv; redirect_target = tgt; trap = tr; imem_ready = rdy;
    #1;
    chk_bit({tag, ".valid"}, pc_valid, exp_valid);
    e.tag = tag; e.pc = exp_pc; e.req = exp_req; e.mis = exp_mis;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    exp_t e;
    logic [31:0] mis_pc;
    logic        mis_bit;
`ifdef PC_MISALIGN_TRAP_EN
    mis_pc  = 32'h0000_0100;
    mis_bit = 1'b1;
`else
    mis_pc  = 32'h0000_0400;
    mis_bit = 1'b0;
`endif
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    trap = 1'b1; imem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_bit("reset.valid", pc_valid, 1'b0);
    e.tag = "reset"; e.pc = 32'h0; e.req = 1'b0; e.mis = 1'b0;
    sb.push_back(e);
    pop_check();
    trap = 1'b0;
    rst_n = 1'b1;

    // BOOT ignores trap and redirect.
    cyc("boot",     0, 1, 32'h400, 1, 1, 0, 32'h0000_0000, 1, 0);
    cyc("seq0",     0, 0, 32'h0,   0, 1, 1, 32'h0000_0004, 1, 0);
    cyc("seq4",     0, 0, 32'h0,   0, 1, 1, 32'h0000_0008, 1, 0);
    cyc("redir1k",  0, 1, 32'h1000,0, 1, 0, 32'h0000_1000, 1, 0);
    for (int i = 0; i < 3; i++)
      cyc("notready",0, 0, 32'h0,  0, 0, 0, 32'h0000_1000, 1, 0);
    cyc("ready",    0, 0, 32'h0,   0, 1, 1, 32'h0000_1004, 1, 0);
    cyc("redir20",  0, 1, 32'h20,  0, 1, 0, 32'h0000_0020, 1, 0);
    for (int i = 0; i < 2; i++)
      cyc("stall",  1, 0, 32'h0,   0, 1, 0, 32'h0000_0020, 0, 0);
    cyc("unstall",  0, 0, 32'h0,   0, 1, 0, 32'h0000_0020, 1, 0);
    cyc("reissue",  0, 0, 32'h0,   0, 1, 1, 32'h0000_0024, 1, 0);
    cyc("trapredir",0, 1, 32'h400, 1, 1, 0, 32'h0000_0100, 1, 0);
    cyc("redir400", 0, 1, 32'h400, 0, 1, 0, 32'h0000_0400, 1, 0);
    cyc("redirtop", 0, 1, 32'hFFFF_FFFC, 0, 1, 0, 32'hFFFF_FFFC, 1, 0);
    cyc("wrap",     0, 0, 32'h0,   0, 1, 1, 32'h0000_0000, 1, 0);
    cyc("redir402", 0, 1, 32'h402, 0, 1, 0, mis_pc, 1, mis_bit);
    cyc("after402", 0, 0, 32'h0,   0, 1, 1, mis_pc + 32'd4, 1, 0);
    cyc("stall2",   1, 0, 32'h0,   0, 1, 0, mis_pc + 32'd4, 0, 0);
    cyc("traphold", 0, 0, 32'h0,   1, 1, 0, 32'h0000_0100, 1, 0);
    cyc("redirstl", 1, 1, 32'h80,  0, 1, 0, 32'h0000_0080, 1, 0);

    // Asynchronous reset in the middle of a pending fetch.
    stall = 1'b0; redirect_valid = 1'b0; trap = 1'b0; imem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    e.tag = "asyncrst"; e.pc = 32'h0; e.req = 1'b0; e.mis = 1'b0;
    sb.push_back(e);
    pop_check();
    chk_bit("asyncrst.valid", pc_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
